mmio_uart_ctrl: RTL and testbench



---
 rtl/mmio_uart_ctrl.sv | 117 +++++++++++
 tb/tb_mmio_uart_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: memory-mapped UART bridge with TX/RX FIFOs and optional cycle/instruction counters.
//
// Ports:
//   clk, rst        - CPU clock; asynchronous active-high reset
//   addr, wdata     - execute-stage address and store data (only wdata[7:0] is used)
//   we, re          - store / load strobes in execute
//   inst_retired    - one instruction retired this cycle (counted only with MMIO_COUNTERS_EN)
//   rdata           - registered load data, valid the cycle after re
//   uart_tx_*       - byte stream to the UART transmitter (valid/ready)
//   uart_rx_*       - byte stream from the UART receiver (valid/ready)
//
// Build option: define MMIO_COUNTERS_EN to include the 32-bit cycle and retired-instruction
// counters at 0x10/0x14 (cleared by a write to 0x18); otherwise those reads return 0.
module mmio_uart_ctrl #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic        re,
   input  logic        inst_retired,
   output logic [31:0] rdata,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic        hit;
   logic [7:0]  sel;
   logic [31:0] cyc_val, ins_val, rd_val;
   assign hit = addr[31:28] == 4'h8;
   assign sel = addr[7:0];
   // TX FIFO: pointers carry an extra wrap bit so full and empty are distinguishable
   logic [7:0]  tx_mem [FIFO_DEPTH];
   logic [AW:0] tx_wp, tx_rp;
   logic        tx_empty, tx_full, tx_push, tx_pop;
   assign tx_empty = tx_wp == tx_rp;
   assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
   assign tx_push  = we && hit && sel == 8'h08 && !tx_full;
   assign tx_pop   = !tx_empty && uart_tx_ready;
   assign uart_tx_valid = !tx_empty;
   assign uart_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rp[AW-1:0]];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wp <= '0;
         tx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop) tx_rp <= tx_rp + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wdata[7:0];
   end
   // RX FIFO: a full FIFO deasserts ready so the UART holds its byte
   logic [7:0]  rx_mem [FIFO_DEPTH];
   logic [AW:0] rx_wp, rx_rp;
   logic        rx_empty, rx_full, rx_push, rx_pop;
   logic [7:0]  rx_head;
   assign rx_empty = rx_wp == rx_rp;
   assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
   assign rx_push  = uart_rx_valid && !rx_full;
   assign rx_pop   = re && hit && sel == 8'h04 && !rx_empty;
   assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];
   assign uart_rx_ready = !rx_full;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop) rx_rp <= rx_rp + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp[AW-1:0]] <= uart_rx_data;
   end
`ifdef MMIO_COUNTERS_EN
   logic [31:0] cyc_cnt, ins_cnt;
   logic        clr;
   logic        unused;
   assign clr = we && hit && sel == 8'h18;
   assign unused = ^{wdata[31:8], addr[27:8]};
   // a clear wins over the increment of the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst || clr) begin
         cyc_cnt <= '0;
         ins_cnt <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + 1'b1;
         if (inst_retired) ins_cnt <= ins_cnt + 1'b1;
      end
   end
   assign cyc_val = cyc_cnt;
   assign ins_val = ins_cnt;
`else
   logic unused;
   assign unused  = ^{wdata[31:8], addr[27:8], inst_retired};
   assign cyc_val = '0;
   assign ins_val = '0;
`endif
   // load data is taken from the pre-edge state, so status ignores this edge's push/pop
   assign rd_val = !(re && hit) ? 32'h0 :
                   sel == 8'h00 ? {30'h0, !rx_empty, !tx_full} :
                   sel == 8'h04 ? {24'h0, rx_head} :
                   sel == 8'h10 ? cyc_val :
                   sel == 8'h14 ? ins_val : 32'h0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata <= '0;
      else rdata <= rd_val;
   end
endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb_mmio_uart_ctrl: directed self-checking bench for mmio_uart_ctrl.
module tb_mmio_uart_ctrl;
`ifdef MMIO_COUNTERS_EN
   localparam bit CNT = 1'b1;
`else
   localparam bit CNT = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0, wdata = '0, rdata;
   logic        we = 1'b0, re = 1'b0, inst_retired = 1'b0;
   logic [7:0]  uart_tx_data, uart_rx_data = '0;
   logic        uart_tx_valid, uart_tx_ready = 1'b0;
   logic        uart_rx_valid = 1'b0, uart_rx_ready;
   int          checks = 0, errors = 0;
   logic [31:0] d;
   mmio_uart_ctrl #(.FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
      .inst_retired(inst_retired), .rdata(rdata),
      .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
      .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      addr = a;
      re = 1'b1;
      tick();
      re = 1'b0;
      addr = '0;
      v = rdata;
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] v);
      addr = a;
      wdata = v;
      we = 1'b1;
      tick();
      we = 1'b0;
      addr = '0;
   endtask
   initial begin
      tick();
      tick();
      rst = 1'b0;
      check("rst_rdata", rdata, 0);
      check("rst_tx_valid", {31'h0, uart_tx_valid}, 0);
      check("rst_tx_data", {24'h0, uart_tx_data}, 0);
      check("rst_rx_ready", {31'h0, uart_rx_ready}, 1);
      rd(32'h8000_0000, d);
      check("status_reset", d, 32'h1);
      // two bytes held back, then released
      wr(32'h8000_0008, 32'h0000_0041);
      check("tx_valid_after_write", {31'h0, uart_tx_valid}, 1);
      wr(32'h8000_0008, 32'hFFFF_FF42);
      check("tx_head_41", {24'h0, uart_tx_data}, 32'h41);
      uart_tx_ready = 1'b1;
      tick();
      check("tx_head_42", {24'h0, uart_tx_data}, 32'h42);
      check("tx_valid_42", {31'h0, uart_tx_valid}, 1);
      tick();
      check("tx_drained", {31'h0, uart_tx_valid}, 0);
      uart_tx_ready = 1'b0;
      // overfill the TX FIFO: the 9th byte is dropped
      for (int i = 0; i < 8; i++) wr(32'h8000_0008, 32'h50 + i);
      rd(32'h8000_0000, d);
      check("status_tx_full", d, 32'h0);
      wr(32'h8000_0008, 32'h0000_0099);
      uart_tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("tx_drain_%0d", i), {23'h0, uart_tx_valid, uart_tx_data}, 32'h150 + i);
         tick();
      end
      check("tx_9th_dropped", {31'h0, uart_tx_valid}, 0);
      uart_tx_ready = 1'b0;
      // fill the RX FIFO, then keep a 9th byte pending
      uart_rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         uart_rx_data = 8'h10 + 8'(i);
         check($sformatf("rx_ready_%0d", i), {31'h0, uart_rx_ready}, 1);
         tick();
      end
      check("rx_full_ready", {31'h0, uart_rx_ready}, 0);
      uart_rx_data = 8'h18;
      rd(32'h8000_0000, d);
      check("status_rx_full", d, 32'h3);
      rd(32'h8000_0004, d);
      check("rx_pop_10", d, 32'h10);
      check("rx_ready_after_pop", {31'h0, uart_rx_ready}, 1);
      rd(32'h8000_0004, d);
      check("rx_pop_11", d, 32'h11);
      uart_rx_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         rd(32'h8000_0004, d);
         check($sformatf("rx_pop_%0d", i + 2), d, 32'h12 + i);
      end
      rd(32'h8000_0004, d);
      check("rx_empty_read", d, 32'h0);
      rd(32'h8000_0000, d);
      check("status_rx_empty", d, 32'h1);
      rd(32'h8000_0004, d);
      check("rx_empty_read2", d, 32'h0);
      rd(32'h4000_0000, d);
      check("miss_addr", d, 32'h0);
      rd(32'h8000_0020, d);
      check("unmapped_reg", d, 32'h0);
      wr(32'h8000_0000, 32'h0);
      check("no_re_rdata", rdata, 32'h0);
      // counters
      wr(32'h8000_0018, 32'h0);
      for (int i = 0; i < 100; i++) begin
         inst_retired = i < 40;
         tick();
      end
      inst_retired = 1'b0;
      rd(32'h8000_0010, d);
      check("cycle_100", d, CNT ? 32'd100 : 32'd0);
      rd(32'h8000_0014, d);
      check("inst_40", d, CNT ? 32'd40 : 32'd0);
      inst_retired = 1'b1;
      wr(32'h8000_0018, 32'hDEAD_BEEF);
      inst_retired = 1'b0;
      rd(32'h8000_0010, d);
      check("cycle_cleared", d, 32'd0);
      rd(32'h8000_0014, d);
      check("inst_cleared", d, 32'd0);
      rd(32'h8000_0010, d);
      check("cycle_after_clear", d, CNT ? 32'd2 : 32'd0);
      // asynchronous reset mid-operation
      wr(32'h8000_0008, 32'hAA);
      uart_rx_valid = 1'b1;
      uart_rx_data = 8'h33;
      tick();
      uart_rx_valid = 1'b0;
      check("pre_rst_tx_valid", {31'h0, uart_tx_valid}, 1);
      rst = 1'b1;
      #1;
      check("async_rst_tx_valid", {31'h0, uart_tx_valid}, 0);
      check("async_rst_tx_data", {24'h0, uart_tx_data}, 0);
      tick();
      rst = 1'b0;
      rd(32'h8000_0000, d);
      check("status_after_rst", d, 32'h1);
      rd(32'h8000_0004, d);
      check("rx_after_rst", d, 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
